// File: rtl/fetch_ifid_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and a synchronous-read imem (slave).
// Read data always belongs to the address issued in the previous cycle.
interface fetch_ifid_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ifid_stage.sv
// IF stage and IF/ID pipeline register: owns the PC, fetches from a 1-cycle imem, and uses
// a one-entry hold buffer so the in-flight fetch survives a stall.
module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pc_en_i,
  input  logic                IF_ID_en_i,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_pc_i,
  fetch_ifid_stage_if.master  imem,
  output logic [31:0]         inst_ID_o,
  output logic [31:0]         pc_ID_o,
  output logic                valid_ID_o,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o
);

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e             r_state;
  logic [31:0]        r_pc;
  logic               r_f_valid;
  logic [31:0]        r_f_pc;
  logic               r_hold_valid;
  logic [31:0]        r_hold_inst;
  logic [31:0]        r_hold_pc;
  logic               r_valid_id;
  logic [31:0]        r_inst_id;
  logic [31:0]        r_pc_id;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic               w_stall;
  logic               w_req;
  logic               w_src_valid;
  logic [31:0]        w_src_inst;
  logic [31:0]        w_src_pc;
  logic [31:0]        w_redirect_pc;

  always_comb begin
    w_stall       = ~(pc_en_i & IF_ID_en_i);
    w_req         = ~w_stall & ~redirect_i & (r_state != StHold);
    // Held instruction is older than anything in flight, so it always wins.
    w_src_valid   = r_hold_valid | r_f_valid;
    w_src_inst    = r_hold_valid ? r_hold_inst : imem.imem_rdata;
    w_src_pc      = r_hold_valid ? r_hold_pc : r_f_pc;
    w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  assign valid_ID_o  = r_valid_id;
  assign inst_ID_o   = r_inst_id;
  assign pc_ID_o     = r_pc_id;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StBoot;
      r_pc         <= RESET_PC;
      r_f_valid    <= 1'b0;
      r_f_pc       <= 32'h0;
      r_hold_valid <= 1'b0;
      r_hold_inst  <= 32'h0;
      r_hold_pc    <= 32'h0;
      r_valid_id   <= 1'b0;
      r_inst_id    <= NOP_INST;
      r_pc_id      <= 32'h0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CntOne;
      end
      if (redirect_i && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CntOne;
      end

      if (redirect_i) begin
        // Kill all younger work regardless of stall.
        r_state      <= StRun;
        r_pc         <= w_redirect_pc;
        r_f_valid    <= 1'b0;
        r_hold_valid <= 1'b0;
        r_valid_id   <= 1'b0;
        r_inst_id    <= NOP_INST;
      end else begin
        if (w_req) begin
          r_pc      <= r_pc + 32'd4;
          r_f_valid <= 1'b1;
          r_f_pc    <= r_pc;
        end else begin
          r_f_valid <= 1'b0;
        end

        unique case (r_state)
          StBoot, StRun: begin
            if (!w_stall) begin
              r_state    <= StRun;
              r_valid_id <= w_src_valid;
              r_inst_id  <= w_src_valid ? w_src_inst : NOP_INST;
              if (w_src_valid) begin
                r_pc_id <= w_src_pc;
              end
            end else if (r_f_valid && (r_state == StRun)) begin
              // Response arrives now but IF/ID is frozen: park it.
              r_state      <= StHold;
              r_hold_valid <= 1'b1;
              r_hold_inst  <= imem.imem_rdata;
              r_hold_pc    <= r_f_pc;
            end
          end
          StHold: begin
            if (!w_stall) begin
              r_state      <= StRun;
              r_valid_id   <= 1'b1;
              r_inst_id    <= r_hold_inst;
              r_pc_id      <= r_hold_pc;
              r_hold_valid <= 1'b0;
            end
          end
          default: r_state <= StBoot;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Bench for fetch_ifid_stage: directed scenarios with literal expectations, then random
// stall/redirect/reset traffic checked every cycle against a queue-based fetch model.
module tb_fetch_ifid_stage;
  localparam int unsigned CntW   = 6;
  localparam int          CntMax = 63;
  localparam logic [31:0] Nop    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              pc_en = 1'b0;
  logic              if_id_en = 1'b0;
  logic              redirect = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic [31:0]       inst_id;
  logic [31:0]       pc_id;
  logic              valid_id;
  logic [CntW-1:0]   stall_cnt;
  logic [CntW-1:0]   flush_cnt;

  fetch_ifid_stage_if imem_bus();

  fetch_ifid_stage #(
    .RESET_PC (32'h0),
    .NOP_INST (Nop),
    .CNT_W    (CntW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .pc_en_i       (pc_en),
    .IF_ID_en_i    (if_id_en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (imem_bus),
    .inst_ID_o     (inst_id),
    .pc_ID_o       (pc_id),
    .valid_ID_o    (valid_id),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  always #5 clk = ~clk;

  // imem[i] = i; unrequested cycles return junk so stale data cannot pass unnoticed.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  always @(posedge clk) begin
    imem_bus.imem_rdata <= imem_bus.imem_req ? mem_word(imem_bus.imem_addr) : $urandom;
  end

  // Model: fetched-but-not-delivered PCs in a queue; data follows from the PC.
  logic [31:0] m_pc;
  logic [31:0] m_pcid;
  bit          m_valid;
  bit          m_held;
  logic [31:0] m_q[$];
  int          m_scnt;
  int          m_fcnt;
  int          n_chk;
  int          n_pass;

  function automatic logic [31:0] sat(input int c);
    return (c > CntMax) ? CntMax : c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pcid = 32'h0; m_valid = 0; m_held = 0;
    m_q.delete(); m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic drive(input bit pe, input bit ie, input bit rd, input logic [31:0] rpc);
    pc_en = pe; if_id_en = ie; redirect = rd; redirect_pc = rpc;
    #1;
    chk("imem_req", imem_bus.imem_req, rst_ni && pe && ie && !rd && !m_held);
    chk("imem_addr", imem_bus.imem_addr, m_pc);
  endtask

  task automatic clock();
    bit stall;
    bit issue;
    @(posedge clk);
    stall = !(pc_en && if_id_en);
    if (stall) m_scnt++;
    if (redirect) begin
      m_fcnt++;
      m_q.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_valid = 0;
      m_held = 0;
    end else begin
      issue = !stall && !m_held;
      if (!stall) begin
        if (m_q.size() > 0) begin
          m_valid = 1;
          m_pcid = m_q.pop_front();
        end else begin
          m_valid = 0;
        end
        m_held = 0;
      end else if (m_q.size() > 0) begin
        m_held = 1;
      end
      if (issue) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    chk("valid_ID", valid_id, m_valid);
    chk("inst_ID", inst_id, m_valid ? mem_word(m_pcid) : Nop);
    if (m_valid) chk("pc_ID", pc_id, m_pcid);
    chk("stall_cnt", stall_cnt, sat(m_scnt));
    chk("flush_cnt", flush_cnt, sat(m_fcnt));
  endtask

  task automatic step(input bit pe, input bit ie, input bit rd, input logic [31:0] rpc);
    drive(pe, ie, rd, rpc);
    clock();
  endtask

  // Called just after a clock(); pulls reset between edges.
  task automatic async_reset();
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", valid_id, 1'b0);
    chk("rst_inst", inst_id, Nop);
    chk("rst_pc_ID", pc_id, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    chk("rst_flush_cnt", flush_cnt, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", valid_id, 1'b0);
    chk("reset_inst", inst_id, Nop);
    chk("reset_pc_ID", pc_id, 32'h0);
    chk("reset_cnt", stall_cnt, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Stream from reset: first valid on the second edge.
    step(1, 1, 0, 0);
    chk("t1_edge1_valid", valid_id, 1'b0);
    step(1, 1, 0, 0);
    chk("t1_edge2_valid", valid_id, 1'b1);
    chk("t1_edge2_pc", pc_id, 32'h0);
    chk("t1_edge2_inst", inst_id, 32'h0);
    step(1, 1, 0, 0);
    chk("t1_edge3_pc", pc_id, 32'h4);
    chk("t1_edge3_inst", inst_id, 32'h1);

    // Stall three cycles while the fetch at 0x8 is in flight.
    repeat (3) step(0, 0, 0, 0);
    chk("t2_hold_pc", pc_id, 32'h4);
    chk("t2_stall_cnt", stall_cnt, 32'd3);
    drive(1, 1, 0, 0);
    chk("t2_release_noreq", imem_bus.imem_req, 1'b0);
    clock();
    chk("t2_after_pc", pc_id, 32'h8);
    chk("t2_after_inst", inst_id, 32'h2);
    step(1, 1, 0, 0);
    chk("t2_bubble", valid_id, 1'b0);
    step(1, 1, 0, 0);
    chk("t2_next_pc", pc_id, 32'hC);

    // Async reset mid-stream, then restart at RESET_PC.
    async_reset();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t6_restart_pc", pc_id, 32'h0);
    chk("t6_restart_valid", valid_id, 1'b1);

    // Redirect to 0x100 while pc_q = 0x10.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    drive(1, 1, 1, 32'h100);
    chk("t3_pc_q", imem_bus.imem_addr, 32'h10);
    chk("t3_noreq", imem_bus.imem_req, 1'b0);
    clock();
    chk("t3_valid", valid_id, 1'b0);
    chk("t3_inst", inst_id, Nop);
    chk("t3_flush", flush_cnt, 32'd1);
    drive(1, 1, 0, 0);
    chk("t3_addr", imem_bus.imem_addr, 32'h100);
    chk("t3_req", imem_bus.imem_req, 1'b1);
    clock();
    step(1, 1, 0, 0);
    chk("t3_target_pc", pc_id, 32'h100);
    chk("t3_target_inst", inst_id, 32'h40);

    // Enter HOLD, then redirect together with stall; low target bits forced to 0.
    step(0, 1, 0, 0);
    drive(0, 0, 1, 32'h203);
    chk("t4_noreq", imem_bus.imem_req, 1'b0);
    clock();
    chk("t4_valid", valid_id, 1'b0);
    drive(1, 1, 0, 0);
    chk("t4_req", imem_bus.imem_req, 1'b1);
    chk("t4_addr", imem_bus.imem_addr, 32'h200);
    clock();
    step(1, 1, 0, 0);
    chk("t4_target_pc", pc_id, 32'h200);

    // Only IF_ID_en low: full stall.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    chk("t5_addr0", imem_bus.imem_addr, 32'h210);
    chk("t5_noreq0", imem_bus.imem_req, 1'b0);
    clock();
    drive(1, 0, 0, 0);
    chk("t5_addr1", imem_bus.imem_addr, 32'h210);
    clock();
    step(1, 1, 0, 0);
    chk("t5_release_pc", pc_id, 32'h20C);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t5_next_pc", pc_id, 32'h210);

    // Random traffic; long enough to saturate both counters.
    for (int i = 0; i < 2500; i++) begin
      if (($urandom % 400) == 0) async_reset();
      step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 12) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
